// File: rtl/cmp_hyst_monitor_pkg.sv
// Shared types and helpers for the comparator hysteresis monitor.
// The package is cmp_pkg: the FSM state type, the comparator flag width,
// and the one-hot legality check used to qualify samples.
package cmp_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        ARM_HIGH = 2'd1,
        HIGH     = 2'd2,
        ARM_LOW  = 2'd3
    } mon_state_t;

    localparam int CMP_FLAG_W = 3;

    // Returns 1 only when exactly one of {gt, eq, lt} is set.
    function automatic logic is_onehot3(input logic [CMP_FLAG_W-1:0] flags);
        logic ok;
        case (flags)
            3'b001:  ok = 1'b1;
            3'b010:  ok = 1'b1;
            3'b100:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cmp_hyst_monitor_sat_counter.sv
// Saturating up-counter. It holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count qualifying events and stop at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/cmp_hyst_monitor.sv
// Debounce/hysteresis monitor for the 8-bit magnitude comparator flags.
// The alarm rises after DEBOUNCE consecutive "greater" samples and falls
// after DEBOUNCE consecutive "less" samples. "Equal" samples hold the
// current progress, which gives the hysteresis band.
// Optional build macro CMP_MON_STATS_EN enables the per-flag saturating
// statistics counters. Without it, gt_cnt/eq_cnt/lt_cnt are tied to zero.
module cmp_hyst_monitor
    import cmp_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    output logic             alarm,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt
);

    if ((DEBOUNCE < 1) || (DEBOUNCE > 255)) begin : g_bad_debounce
        $error("cmp_hyst_monitor: DEBOUNCE must be in 1..255");
    end

    localparam logic [1:0] ST_LOW      = LOW;
    localparam logic [1:0] ST_ARM_HIGH = ARM_HIGH;
    localparam logic [1:0] ST_HIGH     = HIGH;
    localparam logic [1:0] ST_ARM_LOW  = ARM_LOW;
    localparam logic [7:0] DEB8        = 8'(DEBOUNCE);

    logic [CMP_FLAG_W-1:0] flags_s;
    logic                  sample_ok_s;
    logic                  sample_bad_s;
    logic [1:0]            state_r, next_state_s;
    logic [7:0]            cnt_r, next_cnt_s, cnt_inc_s;
    logic                  next_rise_s, next_fall_s;
    logic                  alarm_r, rise_r, fall_r, err_r;

    assign flags_s      = {a_gt_b, a_eq_b, a_lt_b};
    assign sample_ok_s  = in_valid & is_onehot3(flags_s);
    assign sample_bad_s = in_valid & ~is_onehot3(flags_s);
    assign cnt_inc_s    = cnt_r + 8'd1;

    // Next-state, debounce-count and edge-pulse decision for a legal sample.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        next_rise_s  = 1'b0;
        next_fall_s  = 1'b0;
        if (sample_ok_s) begin
            case (state_r)
                ST_LOW: begin
                    if (a_gt_b) begin
                        if (DEB8 == 8'd1) begin
                            next_state_s = ST_HIGH;
                            next_cnt_s   = 8'd0;
                            next_rise_s  = 1'b1;
                        end else begin
                            next_state_s = ST_ARM_HIGH;
                            next_cnt_s   = 8'd1;
                        end
                    end else begin
                        next_cnt_s = 8'd0;
                    end
                end
                ST_ARM_HIGH: begin
                    if (a_gt_b) begin
                        if (cnt_inc_s == DEB8) begin
                            next_state_s = ST_HIGH;
                            next_cnt_s   = 8'd0;
                            next_rise_s  = 1'b1;
                        end else begin
                            next_cnt_s = cnt_inc_s;
                        end
                    end else if (a_lt_b) begin
                        next_state_s = ST_LOW;
                        next_cnt_s   = 8'd0;
                    end else begin
                        next_cnt_s = cnt_r;
                    end
                end
                ST_HIGH: begin
                    if (a_lt_b) begin
                        if (DEB8 == 8'd1) begin
                            next_state_s = ST_LOW;
                            next_cnt_s   = 8'd0;
                            next_fall_s  = 1'b1;
                        end else begin
                            next_state_s = ST_ARM_LOW;
                            next_cnt_s   = 8'd1;
                        end
                    end else begin
                        next_cnt_s = 8'd0;
                    end
                end
                ST_ARM_LOW: begin
                    if (a_lt_b) begin
                        if (cnt_inc_s == DEB8) begin
                            next_state_s = ST_LOW;
                            next_cnt_s   = 8'd0;
                            next_fall_s  = 1'b1;
                        end else begin
                            next_cnt_s = cnt_inc_s;
                        end
                    end else if (a_gt_b) begin
                        next_state_s = ST_HIGH;
                        next_cnt_s   = 8'd0;
                    end else begin
                        next_cnt_s = cnt_r;
                    end
                end
                default: begin
                    next_state_s = ST_LOW;
                    next_cnt_s   = 8'd0;
                end
            endcase
        end else begin
            next_state_s = state_r;
            next_cnt_s   = cnt_r;
        end
    end

    // Register FSM state, debounce count, alarm level, pulses and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LOW;
            cnt_r   <= 8'd0;
            alarm_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            alarm_r <= (next_state_s == ST_HIGH) || (next_state_s == ST_ARM_LOW);
            rise_r  <= next_rise_s;
            fall_r  <= next_fall_s;
            err_r   <= err_r | sample_bad_s;
        end
    end

    assign state      = state_r;
    assign alarm      = alarm_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign err        = err_r;

`ifdef CMP_MON_STATS_EN
    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sample_ok_s & a_gt_b),
        .count (gt_cnt)
    );
    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sample_ok_s & a_eq_b),
        .count (eq_cnt)
    );
    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sample_ok_s & a_lt_b),
        .count (lt_cnt)
    );
`else
    assign gt_cnt = {CNT_W{1'b0}};
    assign eq_cnt = {CNT_W{1'b0}};
    assign lt_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cmp_hyst_monitor.sv
// Self-checking bench for cmp_hyst_monitor (DEBOUNCE=4, CNT_W=4).
// Reference model: the alarm level plus the length of the current streak of
// samples pushing toward the opposite level. The expected FSM state is
// derived from those two values.
module tb_cmp_hyst_monitor;

    localparam int DEB = 4;
    localparam int CW  = 4;
`ifdef CMP_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, a_gt_b = 1'b0, a_eq_b = 1'b0, a_lt_b = 1'b0;
    logic          alarm, rise_pulse, fall_pulse, err;
    logic [1:0]    state;
    logic [CW-1:0] gt_cnt, eq_cnt, lt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference-model state.
    bit m_alarm, m_rise, m_fall, m_err;
    int m_run, m_gt, m_eq, m_lt;

    typedef struct {
        bit r, v, g, e, l;
        bit [1:0] st;
        bit al, ri, fa, er;
    } vec_t;
    vec_t tbl[$];

    cmp_hyst_monitor #(.DEBOUNCE(DEB), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .a_gt_b     (a_gt_b),
        .a_eq_b     (a_eq_b),
        .a_lt_b     (a_lt_b),
        .alarm      (alarm),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .err        (err),
        .state      (state),
        .gt_cnt     (gt_cnt),
        .eq_cnt     (eq_cnt),
        .lt_cnt     (lt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int m);
        if (!STATS) return 0;
        return (m > (2**CW - 1)) ? (2**CW - 1) : m;
    endfunction

    function automatic int exp_state();
        if (m_alarm) return (m_run == 0) ? 2 : 3;
        return (m_run == 0) ? 0 : 1;
    endfunction

    task automatic model_reset();
        m_alarm = 0; m_rise = 0; m_fall = 0; m_err = 0;
        m_run = 0; m_gt = 0; m_eq = 0; m_lt = 0;
    endtask

    task automatic model_step(input bit v, input bit g, input bit e, input bit l);
        bit push, pull;
        m_rise = 0;
        m_fall = 0;
        if (v) begin
            if (int'(g) + int'(e) + int'(l) != 1) begin
                m_err = 1;
            end else begin
                m_gt += int'(g); m_eq += int'(e); m_lt += int'(l);
                push = m_alarm ? l : g;
                pull = m_alarm ? g : l;
                if (push) begin
                    m_run++;
                    if (m_run >= DEB) begin
                        m_alarm = !m_alarm;
                        if (m_alarm) m_rise = 1; else m_fall = 1;
                        m_run = 0;
                    end
                end else if (pull) begin
                    m_run = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".alarm"}, 32'(alarm), 32'(m_alarm));
        check({tag, ".rise"},  32'(rise_pulse), 32'(m_rise));
        check({tag, ".fall"},  32'(fall_pulse), 32'(m_fall));
        check({tag, ".err"},   32'(err), 32'(m_err));
        check({tag, ".state"}, 32'(state), 32'(exp_state()));
        check({tag, ".gt_cnt"}, 32'(gt_cnt), 32'(exp_cnt(m_gt)));
        check({tag, ".eq_cnt"}, 32'(eq_cnt), 32'(exp_cnt(m_eq)));
        check({tag, ".lt_cnt"}, 32'(lt_cnt), 32'(exp_cnt(m_lt)));
    endtask

    // Apply one cycle of stimulus, update the model and compare everything.
    task automatic step(input string tag, input bit r, input bit v,
                        input bit g, input bit e, input bit l);
        rst = r; in_valid = v; a_gt_b = g; a_eq_b = e; a_lt_b = l;
        @(posedge clk);
        #1;
        if (r) model_reset(); else model_step(v, g, e, l);
        check_all(tag);
    endtask

    initial begin
        bit g, e, l, dir_up;
        int p;
        string tg;

        // Debounced rise, then a broken run.
        tbl.push_back('{1,0,0,0,0, 2'd0, 0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2'd1, 0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2'd1, 0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2'd1, 0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2'd2, 1,1,0,0});
        tbl.push_back('{0,0,1,0,0, 2'd2, 1,0,0,0});
        tbl.push_back('{1,0,0,0,0, 2'd0, 0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2'd1, 0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2'd1, 0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2'd1, 0,0,0,0});
        tbl.push_back('{0,1,0,0,1, 2'd0, 0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2'd1, 0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2'd1, 0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2'd1, 0,0,0,0});

        foreach (tbl[i]) begin
            tg = $sformatf("tbl%0d", i);
            step(tg, tbl[i].r, tbl[i].v, tbl[i].g, tbl[i].e, tbl[i].l);
            check({tg, ".t_state"}, 32'(state), 32'(tbl[i].st));
            check({tg, ".t_alarm"}, 32'(alarm), 32'(tbl[i].al));
            check({tg, ".t_rise"},  32'(rise_pulse), 32'(tbl[i].ri));
            check({tg, ".t_fall"},  32'(fall_pulse), 32'(tbl[i].fa));
            check({tg, ".t_err"},   32'(err), 32'(tbl[i].er));
        end
        check("broken.lt_cnt", 32'(lt_cnt), STATS ? 32'd1 : 32'd0);

        // Hysteresis band: eq samples hold the fall progress.
        step("hy.rst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("hy.gt", 0, 1, 1, 0, 0);
        check("hy.high", 32'(state), 32'd2);
        step("hy.lt1", 0, 1, 0, 0, 1);
        step("hy.eq1", 0, 1, 0, 1, 0);
        step("hy.eq2", 0, 1, 0, 1, 0);
        check("hy.eq_hold", 32'(state), 32'd3);
        step("hy.lt2", 0, 1, 0, 0, 1);
        step("hy.lt3", 0, 1, 0, 0, 1);
        check("hy.still_high", 32'(alarm), 32'd1);
        step("hy.lt4", 0, 1, 0, 0, 1);
        check("hy.fall", 32'(fall_pulse), 32'd1);
        check("hy.alarm0", 32'(alarm), 32'd0);
        check("hy.eq_cnt", 32'(eq_cnt), STATS ? 32'd2 : 32'd0);
        step("hy.idle", 0, 0, 0, 0, 0);
        check("hy.fall_once", 32'(fall_pulse), 32'd0);

        // Illegal flags in ARM_HIGH with cnt=2 are ignored except for err.
        step("il.rst", 1, 0, 0, 0, 0);
        step("il.gt1", 0, 1, 1, 0, 0);
        step("il.gt2", 0, 1, 1, 0, 0);
        step("il.bad", 0, 1, 1, 0, 1);
        check("il.err", 32'(err), 32'd1);
        check("il.state", 32'(state), 32'd1);
        step("il.gt3", 0, 1, 1, 0, 0);
        step("il.gt4", 0, 1, 1, 0, 0);
        check("il.high", 32'(state), 32'd2);
        check("il.rise", 32'(rise_pulse), 32'd1);
        step("il.none", 0, 1, 0, 0, 0);
        check("il.err_sticky", 32'(err), 32'd1);

        // Reset in ARM_LOW with a same-cycle valid lt wins over the sample.
        step("rs.rst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("rs.gt", 0, 1, 1, 0, 0);
        step("rs.lt1", 0, 1, 0, 0, 1);
        step("rs.lt2", 0, 1, 0, 0, 1);
        check("rs.arm_low", 32'(state), 32'd3);
        step("rs.rst_lt", 1, 1, 0, 0, 1);
        check("rs.state0", 32'(state), 32'd0);
        check("rs.no_fall", 32'(fall_pulse), 32'd0);
        check("rs.alarm0", 32'(alarm), 32'd0);

        // Counter saturation: 20 eq samples.
        for (int i = 0; i < 20; i++) step("sat.eq", 0, 1, 0, 1, 0);
        check("sat.eq_cnt", 32'(eq_cnt), STATS ? 32'd15 : 32'd0);

        // Randomized run against the model, biased to produce long streaks.
        dir_up = 1'b1;
        for (int i = 0; i < 600; i++) begin
            p = int'($urandom_range(0, 99));
            if (p < 10) dir_up = !dir_up;
            if (p < 5) begin
                g = 1'($urandom); e = 1'($urandom); l = 1'($urandom);
            end else if (p < 25) begin
                g = 0; e = 1; l = 0;
            end else begin
                g = dir_up; e = 0; l = !dir_up;
            end
            step("rnd", ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), g, e, l);
            check("rnd.pulse_excl", 32'(rise_pulse & fall_pulse), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
